pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, program counter width in bits.
REQ-002 SHALL have port CLK  input  1  rising-edge system clock.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-004 SHALL have port FROM_IMMED  input  PC_WIDTH  branch/call target from instruction immediate.
REQ-005 SHALL have port FROM_STACK  input  PC_WIDTH  return address read from stack.
REQ-006 SHALL have port JMP / CALL / RET  input  1 each  decoded flow-control class of the current instruction, valid in EXEC.
REQ-007 SHALL have port RETIE  input  1  return-and-enable-interrupts, valid in EXEC.
REQ-008 SHALL have port SEI / CLI  input  1 each  set/clear interrupt enable, valid in EXEC.
REQ-009 SHALL have port INT  input  1  level interrupt request.
REQ-010 SHALL have port PC_COUNT  output  PC_WIDTH  current program counter (registered).
REQ-011 SHALL have port PC_MUX_SEL  output  2  select: 0 FROM_IMMED, 1 FROM_STACK, 2 all-ones vector, 3 zero.
REQ-012 SHALL have ports PC_LD, PC_INC, IR_LD, STACK_PUSH, STACK_POP, INT_ACK  output  1 each  single-cycle strobes.
REQ-013 SHALL have port STACK_DATA  output  PC_WIDTH  value to push; equals PC_COUNT.
REQ-014 SHALL have port IE  output  1  interrupt-enable flag.

Function
REQ-015 SHALL implement FSM states INIT, FETCH, EXEC, INTR; all strobes 0 unless stated.
REQ-016 INIT: PC_MUX_SEL=3, PC_LD=1 (PC<=0); next FETCH.
REQ-017 FETCH: IR_LD=1, PC_INC=1 (PC<=PC+1, modulo 2^PC_WIDTH, 0x3FF wraps to 0x000); next EXEC.
REQ-018 EXEC, RET or RETIE: PC_MUX_SEL=1, PC_LD=1, STACK_POP=1; RETIE additionally sets IE.
REQ-019 EXEC, CALL: PC_MUX_SEL=0, PC_LD=1, STACK_PUSH=1 with STACK_DATA = already-incremented PC (return address).
REQ-020 EXEC, JMP: PC_MUX_SEL=0, PC_LD=1.
REQ-021 EXEC priority when several flow inputs high: RET/RETIE > CALL > JMP; only one action taken.
REQ-022 EXEC: SEI sets IE, CLI clears IE; both high -> IE cleared; RETIE with CLI -> IE cleared.
REQ-023 EXEC exit: INT=1 and IE=1 (value before this cycle's update) -> INTR, else FETCH.
REQ-024 INTR: STACK_PUSH=1 (STACK_DATA=PC_COUNT after EXEC update), PC_MUX_SEL=2, PC_LD=1 (PC<=all ones), IE<=0, INT_ACK=1; next FETCH.
REQ-025 INT SHALL be ignored outside EXEC; request held through INTR is not re-taken until IE set again.
REQ-026 PC_LD and PC_INC SHALL never be high in the same cycle.
REQ-027 PC_MUX_SEL SHALL be 0 in cycles with PC_LD=0.

Reset
REQ-028 RST=1 SHALL force state INIT, PC_COUNT=0, IE=0, all strobes 0 in the following cycle, from any state including mid-INTR or mid-EXEC.
REQ-029 First FETCH SHALL occur two cycles after RST deasserts (one INIT cycle).

Structure
REQ-030 Package pc_seq_pkg SHALL hold the state enum and PC_MUX_SEL encoding constants (SEL_IMMED, SEL_STACK, SEL_INTR, SEL_ZERO).
REQ-031 Sub-module pc_reg SHALL hold the PC register with RST/PC_LD/PC_INC and the 4:1 source mux.

Verification
REQ-032 Reset then no flow inputs for 6 cycles -> INIT, FETCH/EXEC alternate, PC_COUNT 0,1,1,2,2,3.
REQ-033 At PC_COUNT=0x005 in EXEC, CALL=1, FROM_IMMED=0x120 -> STACK_PUSH with STACK_DATA=0x005, PC_COUNT=0x120 next cycle.
REQ-034 EXEC with RET=1, CALL=1, JMP=1, FROM_STACK=0x044 -> STACK_POP only, PC_COUNT=0x044, no push.
REQ-035 SEI in EXEC, INT=1 in next EXEC at PC_COUNT=0x031 -> INTR: push 0x031, PC_COUNT=0x3FF, INT_ACK=1, IE=0; following FETCH gives PC_COUNT 0x000 (wrap).
REQ-036 INT=1 with IE=0; and SEI+CLI together -> IE stays 0, no INTR entered.
REQ-037 RST asserted during INTR -> next cycle state INIT, PC_COUNT=0, IE=0, no INT_ACK.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_INTR  = 2'd3
   } state_t;

   // PC source mux encoding
   localparam logic [1:0] SEL_IMMED = 2'd0;
   localparam logic [1:0] SEL_STACK = 2'd1;
   localparam logic [1:0] SEL_INTR  = 2'd2;
   localparam logic [1:0] SEL_ZERO  = 2'd3;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with synchronous reset, load from a 4:1 source mux, and increment.
module pc_reg
   import pc_seq_pkg::*;
#(
   parameter int unsigned PC_WIDTH = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld,
   input  logic                inc,
   input  logic [1:0]          sel,
   input  logic [PC_WIDTH-1:0] immed,
   input  logic [PC_WIDTH-1:0] stack,
   output logic [PC_WIDTH-1:0] count
);

   logic [PC_WIDTH-1:0] src;

   always_comb begin
      src = '0;
      case (sel)
         SEL_IMMED: src = immed;
         SEL_STACK: src = stack;
         SEL_INTR:  src = '1;
         default:   src = '0;
      endcase
   end

   // Load wins over increment; increment wraps naturally at the register width
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (ld)
         count <= src;
      else if (inc)
         count <= count + PC_WIDTH'(1);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/interrupt sequencer driving the PC, instruction register and call stack.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned PC_WIDTH = 10
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [PC_WIDTH-1:0] FROM_IMMED,
   input  logic [PC_WIDTH-1:0] FROM_STACK,
   input  logic                JMP,
   input  logic                CALL,
   input  logic                RET,
   input  logic                RETIE,
   input  logic                SEI,
   input  logic                CLI,
   input  logic                INT,
   output logic [PC_WIDTH-1:0] PC_COUNT,
   output logic [1:0]          PC_MUX_SEL,
   output logic                PC_LD,
   output logic                PC_INC,
   output logic                IR_LD,
   output logic                STACK_PUSH,
   output logic                STACK_POP,
   output logic                INT_ACK,
   output logic [PC_WIDTH-1:0] STACK_DATA,
   output logic                IE
);

   state_t state, state_next;
   logic   ie_next;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_INIT;
         IE    <= 1'b0;
      end else begin
         state <= state_next;
         IE    <= ie_next;
      end
   end

   // Strobes are held low while reset is asserted, whatever the current state
   always_comb begin
      state_next = state;
      ie_next    = IE;
      PC_MUX_SEL = SEL_IMMED;
      PC_LD      = 1'b0;
      PC_INC     = 1'b0;
      IR_LD      = 1'b0;
      STACK_PUSH = 1'b0;
      STACK_POP  = 1'b0;
      INT_ACK    = 1'b0;
      if (!RST) begin
         case (state)
            ST_INIT: begin
               PC_MUX_SEL = SEL_ZERO;
               PC_LD      = 1'b1;
               state_next = ST_FETCH;
            end
            ST_FETCH: begin
               IR_LD      = 1'b1;
               PC_INC     = 1'b1;
               state_next = ST_EXEC;
            end
            ST_EXEC: begin
               if (RET || RETIE) begin
                  PC_MUX_SEL = SEL_STACK;
                  PC_LD      = 1'b1;
                  STACK_POP  = 1'b1;
               end else if (CALL) begin
                  PC_LD      = 1'b1;
                  STACK_PUSH = 1'b1;
               end else if (JMP) begin
                  PC_LD      = 1'b1;
               end
               if (CLI)
                  ie_next = 1'b0;
               else if (SEI || RETIE)
                  ie_next = 1'b1;
               // Interrupt decision uses the enable as it stood entering this cycle
               state_next = (INT && IE) ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
               PC_MUX_SEL = SEL_INTR;
               PC_LD      = 1'b1;
               STACK_PUSH = 1'b1;
               INT_ACK    = 1'b1;
               ie_next    = 1'b0;
               state_next = ST_FETCH;
            end
            default: state_next = ST_INIT;
         endcase
      end
   end

   assign STACK_DATA = PC_COUNT;

   pc_reg #(.PC_WIDTH(PC_WIDTH)) u_pc_reg (
      .clk   (CLK),
      .rst   (RST),
      .ld    (PC_LD),
      .inc   (PC_INC),
      .sel   (PC_MUX_SEL),
      .immed (FROM_IMMED),
      .stack (FROM_STACK),
      .count (PC_COUNT)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a cycle-level architectural model.
module tb_pc_sequencer;

   localparam int unsigned PCW  = 10;
   localparam int          MASK = (1 << PCW) - 1;
   localparam int P_INIT = 0, P_FETCH = 1, P_EXEC = 2, P_INTR = 3;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic [PCW-1:0] FROM_IMMED = '0, FROM_STACK = '0;
   logic           JMP = 0, CALL = 0, RET = 0, RETIE = 0, SEI = 0, CLI = 0, INT = 0;
   logic [PCW-1:0] PC_COUNT, STACK_DATA;
   logic [1:0]     PC_MUX_SEL;
   logic           PC_LD, PC_INC, IR_LD, STACK_PUSH, STACK_POP, INT_ACK, IE;

   int n_checks = 0;
   int n_fail   = 0;

   // architectural model
   int m_phase = P_INIT;
   int m_pc    = 0;
   int m_ie    = 0;

   pc_sequencer #(.PC_WIDTH(PCW)) dut (
      .CLK(CLK), .RST(RST), .FROM_IMMED(FROM_IMMED), .FROM_STACK(FROM_STACK),
      .JMP(JMP), .CALL(CALL), .RET(RET), .RETIE(RETIE), .SEI(SEI), .CLI(CLI), .INT(INT),
      .PC_COUNT(PC_COUNT), .PC_MUX_SEL(PC_MUX_SEL), .PC_LD(PC_LD), .PC_INC(PC_INC),
      .IR_LD(IR_LD), .STACK_PUSH(STACK_PUSH), .STACK_POP(STACK_POP), .INT_ACK(INT_ACK),
      .STACK_DATA(STACK_DATA), .IE(IE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare this cycle's outputs, then advance the model
   task automatic step(input bit rst, input logic [PCW-1:0] im, input logic [PCW-1:0] st,
                       input bit jmp, input bit call, input bit ret, input bit retie,
                       input bit sei, input bit cli, input bit irq);
      int e_sel, e_ld, e_inc, e_ir, e_push, e_pop, e_ack, old_ie;
      @(negedge CLK);
      RST = rst; FROM_IMMED = im; FROM_STACK = st;
      JMP = jmp; CALL = call; RET = ret; RETIE = retie; SEI = sei; CLI = cli; INT = irq;
      #1;
      e_sel = 0; e_ld = 0; e_inc = 0; e_ir = 0; e_push = 0; e_pop = 0; e_ack = 0;
      if (!rst) begin
         if (m_phase == P_INIT) begin
            e_ld = 1; e_sel = 3;
         end else if (m_phase == P_FETCH) begin
            e_ir = 1; e_inc = 1;
         end else if (m_phase == P_EXEC) begin
            if (ret || retie) begin
               e_ld = 1; e_sel = 1; e_pop = 1;
            end else if (call || jmp) begin
               e_ld = 1; e_push = int'(call);
            end
         end else begin
            e_push = 1; e_ld = 1; e_sel = 2; e_ack = 1;
         end
      end
      check("pc_count",   32'(PC_COUNT),   32'(m_pc));
      check("stack_data", 32'(STACK_DATA), 32'(m_pc));
      check("ie",         32'(IE),         32'(m_ie));
      check("pc_mux_sel", 32'(PC_MUX_SEL), 32'(e_sel));
      check("pc_ld",      32'(PC_LD),      32'(e_ld));
      check("pc_inc",     32'(PC_INC),     32'(e_inc));
      check("ir_ld",      32'(IR_LD),      32'(e_ir));
      check("stack_push", 32'(STACK_PUSH), 32'(e_push));
      check("stack_pop",  32'(STACK_POP),  32'(e_pop));
      check("int_ack",    32'(INT_ACK),    32'(e_ack));
      check("ld_inc_excl", 32'(PC_LD & PC_INC), 32'(0));
      @(posedge CLK);
      if (rst) begin
         m_phase = P_INIT; m_pc = 0; m_ie = 0;
      end else if (m_phase == P_INIT) begin
         m_pc = 0; m_phase = P_FETCH;
      end else if (m_phase == P_FETCH) begin
         m_pc = (m_pc + 1) & MASK; m_phase = P_EXEC;
      end else if (m_phase == P_EXEC) begin
         old_ie = m_ie;
         if (ret || retie)     m_pc = int'(st);
         else if (call || jmp) m_pc = int'(im);
         if (cli)                m_ie = 0;
         else if (sei || retie)  m_ie = 1;
         m_phase = (irq && old_ie == 1) ? P_INTR : P_FETCH;
      end else begin
         m_pc = MASK; m_ie = 0; m_phase = P_FETCH;
      end
   endtask

   task automatic idle();
      step(0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      m_phase = P_INIT; m_pc = 0; m_ie = 0;

      // Idle after reset: INIT then alternating FETCH/EXEC
      repeat (6) idle();
      #1 check("idle_pc_exec", 32'(PC_COUNT), 32'h003);

      // Reach EXEC at 0x005 then CALL 0x120
      step(0, 10'h004, '0, 1, 0, 0, 0, 0, 0, 0);
      idle();
      step(0, 10'h120, '0, 0, 1, 0, 0, 0, 0, 0);
      #1 check("call_target", 32'(PC_COUNT), 32'h120);

      // All flow inputs at once: return wins
      idle();
      step(0, 10'h2AA, 10'h044, 1, 1, 1, 0, 0, 0, 0);
      #1 check("ret_priority", 32'(PC_COUNT), 32'h044);

      // SEI with jump to 0x030, then interrupt taken in EXEC at 0x031
      idle();
      step(0, 10'h030, '0, 1, 0, 0, 0, 1, 0, 0);
      idle();
      step(0, '0, '0, 0, 0, 0, 0, 0, 0, 1);
      step(0, '0, '0, 0, 0, 0, 0, 0, 0, 1);
      #1 check("intr_vector", 32'(PC_COUNT), 32'h3FF);
      check("intr_ie_clr", 32'(IE), 32'h0);
      idle();
      #1 check("pc_wrap", 32'(PC_COUNT), 32'h000);

      // Interrupt with IE clear, and SEI+CLI together, never enter INTR
      step(0, '0, '0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      step(0, '0, '0, 0, 0, 0, 0, 1, 1, 1);
      #1 check("sei_cli_ie", 32'(IE), 32'h0);
      idle();
      step(0, '0, '0, 0, 0, 0, 0, 0, 0, 1);

      // Reset asserted during INTR
      idle();
      step(0, '0, '0, 0, 0, 0, 0, 1, 0, 0);
      idle();
      step(0, '0, '0, 0, 0, 0, 0, 0, 0, 1);
      step(1, '0, '0, 0, 0, 0, 0, 0, 0, 1);
      #1 check("rst_intr_pc", 32'(PC_COUNT), 32'h0);
      check("rst_intr_ie", 32'(IE), 32'h0);
      idle();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 59) == 0,
              PCW'($urandom), PCW'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 6) == 0, $urandom_range(0, 8) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 1) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
